cordic_sincos: RTL

CORDIC_SINCOS -- requirements
Module: cordic_sincos

---
 rtl/cordic_sincos_if.sv | 24 ++
 rtl/cordic_sincos.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_sincos_if.sv
// Stream bundle for cordic_sincos: phase input channel and {sin, cos} result channel.
interface cordic_sincos_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned USER_W = 4
);
  logic [WIDTH-1:0]   s_axis_phase_tdata;
  logic               s_axis_phase_tvalid;
  logic [USER_W-1:0]  s_axis_phase_tuser;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;
  logic               m_axis_dout_tvalid;
  logic [USER_W-1:0]  m_axis_dout_tuser;

  // Core side: consumes phases, produces results
  modport slave (
    input  s_axis_phase_tdata, s_axis_phase_tvalid, s_axis_phase_tuser,
    output m_axis_dout_tdata, m_axis_dout_tvalid, m_axis_dout_tuser
  );

  // Client side: issues phases, observes results
  modport master (
    output s_axis_phase_tdata, s_axis_phase_tvalid, s_axis_phase_tuser,
    input  m_axis_dout_tdata, m_axis_dout_tvalid, m_axis_dout_tuser
  );
endinterface

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC producing {sin, cos} of a Q3 phase, one micro-rotation per cycle.
// Optional sticky overrun flag output enabled by defining CORDIC_DROP_FLAG_EN.
module cordic_sincos #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ITERS  = 14,
  parameter int unsigned USER_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  cordic_sincos_if.slave  bus,
  output logic            busy
`ifdef CORDIC_DROP_FLAG_EN
  ,
  output logic            drop
`endif
);

  localparam int unsigned DW    = WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(ITERS);
  localparam int unsigned SH_Z  = 30 - (WIDTH - 3);
  localparam int unsigned SH_X  = 30 - (WIDTH - 2);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ROT  = 1'b1;

  // Round-to-nearest rescale of a Q30 constant down to the working fraction width
  function automatic longint unsigned rnd_q30(input longint unsigned v, input int unsigned sh);
    return (v + (64'd1 << (sh - 1))) >> sh;
  endfunction

  // atan(2^-i) in Q30 radians
  function automatic longint unsigned atan_q30(input int unsigned i);
    case (i)
      0:  return 64'h3243F6A8;
      1:  return 64'h1DAC6705;
      2:  return 64'h0FADBAFC;
      3:  return 64'h07F56EA6;
      4:  return 64'h03FEAB76;
      5:  return 64'h01FFD55B;
      6:  return 64'h00FFFAAA;
      7:  return 64'h007FFF55;
      8:  return 64'h003FFFEA;
      9:  return 64'h001FFFFD;
      default: return (i <= 30) ? (64'd1 << (30 - i)) - 64'd1 : 64'd0;
    endcase
  endfunction

  localparam logic signed [DW-1:0] PI_Z    = DW'(rnd_q30(64'hC90FDAA2, SH_Z));
  localparam logic signed [DW-1:0] HALF_Z  = DW'(rnd_q30(64'h6487ED51, SH_Z));
  localparam logic signed [DW-1:0] NHALF_Z = -HALF_Z;
  localparam logic signed [DW-1:0] K_X     = DW'(rnd_q30(64'h26DD3B6A, SH_X));
  localparam logic signed [DW-1:0] SAT_MAX = DW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [DW-1:0] SAT_MIN = -SAT_MAX - DW'(1);

  function automatic logic [WIDTH-1:0] sat(input logic signed [DW-1:0] v);
    if (v > SAT_MAX) return WIDTH'(SAT_MAX);
    if (v < SAT_MIN) return WIDTH'(SAT_MIN);
    return WIDTH'(v);
  endfunction

  logic signed [DW-1:0] atan_tab [ITERS];
  for (genvar g = 0; g < ITERS; g++) begin : g_atan
    assign atan_tab[g] = DW'(rnd_q30(atan_q30(g), SH_Z));
  end

  logic [0:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic signed [DW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic                 neg_q, neg_d;
  logic [USER_W-1:0]    tag_q, tag_d;
  logic                 tvalid_q, tvalid_d;
  logic [2*WIDTH-1:0]   tdata_q, tdata_d;
  logic [USER_W-1:0]    tuser_q, tuser_d;
  logic                 busy_q, busy_d;
`ifdef CORDIC_DROP_FLAG_EN
  logic                 drop_q, drop_d;
`endif

  logic signed [DW-1:0] phase_ext, x_rot, y_rot, z_rot, x_sh, y_sh;
  logic [WIDTH-1:0]     sin_sat, cos_sat;

  // One micro-rotation from the current x/y/z, plus folded-sign final outputs
  always_comb begin
    phase_ext = DW'($signed(bus.s_axis_phase_tdata));
    x_sh      = x_q >>> cnt_q;
    y_sh      = y_q >>> cnt_q;
    if (!z_q[DW-1]) begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_tab[cnt_q];
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_tab[cnt_q];
    end
    sin_sat = sat(neg_q ? -y_rot : y_rot);
    cos_sat = sat(neg_q ? -x_rot : x_rot);
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    neg_d    = neg_q;
    tag_d    = tag_q;
    tvalid_d = 1'b0;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
`ifdef CORDIC_DROP_FLAG_EN
    drop_d   = drop_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.s_axis_phase_tvalid) begin
          state_d = S_ROT;
          cnt_d   = '0;
          tag_d   = bus.s_axis_phase_tuser;
          x_d     = K_X;
          y_d     = '0;
          if (phase_ext > HALF_Z) begin
            z_d   = phase_ext - PI_Z;
            neg_d = 1'b1;
          end else if (phase_ext < NHALF_Z) begin
            z_d   = phase_ext + PI_Z;
            neg_d = 1'b1;
          end else begin
            z_d   = phase_ext;
            neg_d = 1'b0;
          end
        end
      end
      S_ROT: begin
        x_d   = x_rot;
        y_d   = y_rot;
        z_d   = z_rot;
        cnt_d = cnt_q + CNT_W'(1);
`ifdef CORDIC_DROP_FLAG_EN
        if (bus.s_axis_phase_tvalid) drop_d = 1'b1;
`endif
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          tvalid_d = 1'b1;
          tdata_d  = {sin_sat, cos_sat};
          tuser_d  = tag_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_ROT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      neg_q    <= 1'b0;
      tag_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      busy_q   <= 1'b0;
`ifdef CORDIC_DROP_FLAG_EN
      drop_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      neg_q    <= neg_d;
      tag_q    <= tag_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      busy_q   <= busy_d;
`ifdef CORDIC_DROP_FLAG_EN
      drop_q   <= drop_d;
`endif
    end
  end

  assign bus.m_axis_dout_tvalid = tvalid_q;
  assign bus.m_axis_dout_tdata  = tdata_q;
  assign bus.m_axis_dout_tuser  = tuser_q;
  assign busy                   = busy_q;
`ifdef CORDIC_DROP_FLAG_EN
  assign drop                   = drop_q;
`endif

endmodule
